// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement queue; allocates at tail, marks done on
//               writeback, retires head in order, truncates on mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PREG_W = 7,
    parameter int AREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic [TAG_W-1:0]  dispatch_rob_tag,
    input  logic [AREG_W-1:0] dispatch_rd,
    input  logic [PREG_W-1:0] dispatch_prd,
    input  logic [PREG_W-1:0] dispatch_old_prd,
    input  logic              dispatch_reg_write,
    input  logic              dispatch_is_branch,
    output logic [TAG_W-1:0]  rob_tail_tag,
    input  logic              wb0_valid,
    input  logic [TAG_W-1:0]  wb0_tag,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic              mispredict_valid,
    input  logic [TAG_W-1:0]  mispredict_tag,
    output logic              commit_retire,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [AREG_W-1:0] commit_rd,
    output logic [PREG_W-1:0] commit_prd,
    output logic              commit_en,
    output logic [PREG_W-1:0] commit_old_preg,
    output logic              tag_error
);

    localparam logic [TAG_W:0] c_full_count = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_reg_write;
    logic [AREG_W-1:0] r_rd      [DEPTH];
    logic [PREG_W-1:0] r_prd     [DEPTH];
    logic [PREG_W-1:0] r_old_prd [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;
    logic              r_tag_error;

    logic              r_commit_retire;
    logic [TAG_W-1:0]  r_commit_tag;
    logic [AREG_W-1:0] r_commit_rd;
    logic [PREG_W-1:0] r_commit_prd;
    logic              r_commit_en;
    logic [PREG_W-1:0] r_commit_old_preg;

    logic              w_commit;
    logic              w_mispredict;
    logic              w_accept;
    logic [TAG_W-1:0]  w_mp_offset;
    logic [DEPTH-1:0]  w_flush;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [DEPTH-1:0]  w_done_nxt;
    logic [TAG_W-1:0]  w_tail_nxt;
    logic [TAG_W:0]    w_count_nxt;

    // Branch flag is carried by rename for its own use; nothing here needs it.
    logic w_unused_is_branch;
    assign w_unused_is_branch = dispatch_is_branch;

    assign dispatch_ready = reset & (r_count != c_full_count);
    assign rob_tail_tag   = r_tail;

    assign w_commit     = r_valid[r_head] & r_done[r_head];
    assign w_mispredict = mispredict_valid & r_valid[mispredict_tag];
    assign w_accept     = dispatch_valid & dispatch_ready & ~w_mispredict;
    assign w_mp_offset  = mispredict_tag - r_head;

    // An entry is younger than the branch when its distance from head exceeds
    // the branch's; using head-relative distance keeps the full case correct.
    always_comb begin
        w_flush = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_mispredict && ((TAG_W'(i) - r_head) > w_mp_offset)) begin
                w_flush[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_valid_nxt = r_valid & ~w_flush;
        w_done_nxt  = r_done & ~w_flush;
        if (w_commit) begin
            w_valid_nxt[r_head] = 1'b0;
        end
        if (wb0_valid && r_valid[wb0_tag] && !w_flush[wb0_tag]) begin
            w_done_nxt[wb0_tag] = 1'b1;
        end
        if (wb1_valid && r_valid[wb1_tag] && !w_flush[wb1_tag]) begin
            w_done_nxt[wb1_tag] = 1'b1;
        end
        if (w_accept) begin
            w_valid_nxt[r_tail] = 1'b1;
            w_done_nxt[r_tail]  = 1'b0;
        end
    end

    always_comb begin
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count + (TAG_W+1)'(w_accept) - (TAG_W+1)'(w_commit);
        if (w_mispredict) begin
            w_tail_nxt  = mispredict_tag + TAG_W'(1);
            w_count_nxt = {1'b0, w_mp_offset} + (TAG_W+1)'(1) - (TAG_W+1)'(w_commit);
        end else if (w_accept) begin
            w_tail_nxt = r_tail + TAG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid           <= '0;
            r_done            <= '0;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_tag_error       <= 1'b0;
            r_commit_retire   <= 1'b0;
            r_commit_tag      <= '0;
            r_commit_rd       <= '0;
            r_commit_prd      <= '0;
            r_commit_en       <= 1'b0;
            r_commit_old_preg <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            if (w_commit) begin
                r_head <= r_head + TAG_W'(1);
            end
            if (w_accept) begin
                r_rd[r_tail]        <= dispatch_rd;
                r_prd[r_tail]       <= dispatch_prd;
                r_old_prd[r_tail]   <= dispatch_old_prd;
                r_reg_write[r_tail] <= dispatch_reg_write;
                if (dispatch_rob_tag != r_tail) begin
                    r_tag_error <= 1'b1;
                end
            end
            r_commit_retire   <= w_commit;
            r_commit_tag      <= w_commit ? r_head : '0;
            r_commit_rd       <= w_commit ? r_rd[r_head] : '0;
            r_commit_prd      <= w_commit ? r_prd[r_head] : '0;
            r_commit_en       <= w_commit & r_reg_write[r_head];
            r_commit_old_preg <= w_commit ? r_old_prd[r_head] : '0;
        end
    end

    assign commit_retire   = r_commit_retire;
    assign commit_tag      = r_commit_tag;
    assign commit_rd       = r_commit_rd;
    assign commit_prd      = r_commit_prd;
    assign commit_en       = r_commit_en;
    assign commit_old_preg = r_commit_old_preg;
    assign tag_error       = r_tag_error;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed table and sequence bench for reorder_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       dispatch_valid;
    logic       dispatch_ready;
    logic [3:0] dispatch_rob_tag;
    logic [4:0] dispatch_rd;
    logic [6:0] dispatch_prd;
    logic [6:0] dispatch_old_prd;
    logic       dispatch_reg_write;
    logic       dispatch_is_branch;
    logic [3:0] rob_tail_tag;
    logic       wb0_valid;
    logic [3:0] wb0_tag;
    logic       wb1_valid;
    logic [3:0] wb1_tag;
    logic       mispredict_valid;
    logic [3:0] mispredict_tag;
    logic       commit_retire;
    logic [3:0] commit_tag;
    logic [4:0] commit_rd;
    logic [6:0] commit_prd;
    logic       commit_en;
    logic [6:0] commit_old_preg;
    logic       tag_error;

    reorder_buffer #(.DEPTH(16), .TAG_W(4), .PREG_W(7), .AREG_W(5)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rob_tag(dispatch_rob_tag), .dispatch_rd(dispatch_rd),
        .dispatch_prd(dispatch_prd), .dispatch_old_prd(dispatch_old_prd),
        .dispatch_reg_write(dispatch_reg_write), .dispatch_is_branch(dispatch_is_branch),
        .rob_tail_tag(rob_tail_tag),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
        .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
        .commit_retire(commit_retire), .commit_tag(commit_tag),
        .commit_rd(commit_rd), .commit_prd(commit_prd),
        .commit_en(commit_en), .commit_old_preg(commit_old_preg),
        .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [3:0] dtag;
        logic [4:0] rd;
        logic [6:0] prd;
        logic [6:0] old;
        logic       rw;
        logic       wb0v;
        logic [3:0] wb0t;
        logic       wb1v;
        logic [3:0] wb1t;
        logic       e_ready;
        logic [3:0] e_tail;
        logic       e_retire;
        logic [3:0] e_ctag;
        logic       e_cen;
        logic [6:0] e_cold;
    } vec_t;

    vec_t       vt [12];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_tail;
    logic [3:0] cq [$];
    logic [3:0] eq [$];

    // Commits are captured mid-cycle, where the registered pulse is stable.
    always @(negedge clk) begin
        if (commit_retire === 1'b1) cq.push_back(commit_tag);
    end

    function automatic vec_t mk(int dv, int dtag, int rd, int prd, int old, int rw,
                                int w0v, int w0t, int w1v, int w1t,
                                int rdy, int tl, int ret, int ct, int cen, int cold);
        vec_t v;
        v.dv = dv[0];        v.dtag = dtag[3:0];  v.rd = rd[4:0];
        v.prd = prd[6:0];    v.old = old[6:0];    v.rw = rw[0];
        v.wb0v = w0v[0];     v.wb0t = w0t[3:0];   v.wb1v = w1v[0];
        v.wb1t = w1t[3:0];   v.e_ready = rdy[0];  v.e_tail = tl[3:0];
        v.e_retire = ret[0]; v.e_ctag = ct[3:0];  v.e_cen = cen[0];
        v.e_cold = cold[6:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid     = 1'b0;
        dispatch_rob_tag   = '0;
        dispatch_rd        = '0;
        dispatch_prd       = '0;
        dispatch_old_prd   = '0;
        dispatch_reg_write = 1'b0;
        dispatch_is_branch = 1'b0;
        wb0_valid          = 1'b0;
        wb0_tag            = '0;
        wb1_valid          = 1'b0;
        wb1_tag            = '0;
        mispredict_valid   = 1'b0;
        mispredict_tag     = '0;
    endtask

    task automatic disp(input logic [3:0] tag);
        dispatch_valid     = 1'b1;
        dispatch_rob_tag   = tag;
        dispatch_rd        = 5'd7;
        dispatch_prd       = 7'd90;
        dispatch_old_prd   = 7'd60;
        dispatch_reg_write = 1'b1;
        tick();
        dispatch_valid = 1'b0;
        exp_tail       = exp_tail + 4'd1;
        chk("dispatch_tail", 32'(rob_tail_tag), 32'(exp_tail));
    endtask

    task automatic chk_queue(input string name);
        chk({name, "_count"}, 32'(cq.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size() && i < cq.size(); i++) begin
            chk({name, "_tag"}, 32'(cq[i]), 32'(eq[i]));
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        exp_tail = 4'd0;

        vt[0]  = mk(1, 0, 1, 40, 33, 1,  0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, 2, 41, 34, 1,  0, 0, 0, 0,  1, 2, 0, 0, 0, 0);
        vt[2]  = mk(1, 2, 3, 42, 35, 1,  0, 0, 0, 0,  1, 3, 0, 0, 0, 0);
        vt[3]  = mk(0, 0, 0,  0,  0, 0,  1, 2, 0, 0,  1, 3, 0, 0, 0, 0);
        vt[4]  = mk(1, 3, 0, 43, 36, 0,  1, 1, 0, 0,  1, 4, 0, 0, 0, 0);
        vt[5]  = mk(0, 0, 0,  0,  0, 0,  1, 0, 0, 0,  1, 4, 0, 0, 0, 0);
        vt[6]  = mk(0, 0, 0,  0,  0, 0,  0, 0, 0, 0,  1, 4, 1, 0, 1, 33);
        vt[7]  = mk(0, 0, 0,  0,  0, 0,  0, 0, 0, 0,  1, 4, 1, 1, 1, 34);
        vt[8]  = mk(0, 0, 0,  0,  0, 0,  0, 0, 1, 3,  1, 4, 1, 2, 1, 35);
        vt[9]  = mk(0, 0, 0,  0,  0, 0,  0, 0, 0, 0,  1, 4, 1, 3, 0, 36);
        vt[10] = mk(0, 0, 0,  0,  0, 0,  1, 4, 0, 0,  1, 4, 0, 0, 0, 0);
        vt[11] = mk(0, 0, 0,  0,  0, 0,  0, 0, 0, 0,  1, 4, 0, 0, 0, 0);

        // Reset held for two edges
        tick();
        tick();
        chk("rst_ready", 32'(dispatch_ready), 32'd0);
        chk("rst_tail", 32'(rob_tail_tag), 32'd0);
        chk("rst_retire", 32'(commit_retire), 32'd0);
        chk("rst_commit_en", 32'(commit_en), 32'd0);
        chk("rst_old_preg", 32'(commit_old_preg), 32'd0);
        chk("rst_tag_error", 32'(tag_error), 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", 32'(dispatch_ready), 32'd1);
        chk("post_rst_tail", 32'(rob_tail_tag), 32'd0);
        chk("post_rst_retire", 32'(commit_retire), 32'd0);

        // Table: out-of-order writeback, in-order commit, store with no reg write
        for (int i = 0; i < 12; i++) begin
            dispatch_valid     = vt[i].dv;
            dispatch_rob_tag   = vt[i].dtag;
            dispatch_rd        = vt[i].rd;
            dispatch_prd       = vt[i].prd;
            dispatch_old_prd   = vt[i].old;
            dispatch_reg_write = vt[i].rw;
            wb0_valid          = vt[i].wb0v;
            wb0_tag            = vt[i].wb0t;
            wb1_valid          = vt[i].wb1v;
            wb1_tag            = vt[i].wb1t;
            tick();
            chk($sformatf("v%0d_ready", i), 32'(dispatch_ready), 32'(vt[i].e_ready));
            chk($sformatf("v%0d_tail", i), 32'(rob_tail_tag), 32'(vt[i].e_tail));
            chk($sformatf("v%0d_retire", i), 32'(commit_retire), 32'(vt[i].e_retire));
            chk($sformatf("v%0d_ctag", i), 32'(commit_tag), 32'(vt[i].e_ctag));
            chk($sformatf("v%0d_cen", i), 32'(commit_en), 32'(vt[i].e_cen));
            chk($sformatf("v%0d_cold", i), 32'(commit_old_preg), 32'(vt[i].e_cold));
        end
        idle_inputs();
        exp_tail = 4'd4;

        // Mispredict: tags 4..11 live, branch at 7 keeps 4..7
        cq.delete();
        for (int i = 0; i < 8; i++) disp(exp_tail);
        mispredict_valid = 1'b1;
        mispredict_tag   = 4'd7;
        wb0_valid        = 1'b1;
        wb0_tag          = 4'd9;
        dispatch_valid   = 1'b1;
        dispatch_rob_tag = 4'd12;
        tick();
        idle_inputs();
        exp_tail = 4'd8;
        chk("mp_tail", 32'(rob_tail_tag), 32'd8);
        wb0_valid = 1'b1;
        wb0_tag   = 4'd10;
        tick();
        wb0_valid = 1'b0;
        chk("mp_stale_wb_tail", 32'(rob_tail_tag), 32'd8);
        disp(4'd8);
        wb0_valid = 1'b1; wb0_tag = 4'd4; wb1_valid = 1'b1; wb1_tag = 4'd5;
        tick();
        wb0_tag = 4'd6; wb1_tag = 4'd7;
        tick();
        wb0_tag = 4'd8; wb1_valid = 1'b0;
        tick();
        idle_inputs();
        repeat (4) tick();
        eq = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        chk_queue("mp_commits");
        mispredict_valid = 1'b1;
        mispredict_tag   = 4'd3;
        tick();
        mispredict_valid = 1'b0;
        chk("mp_invalid_tail", 32'(rob_tail_tag), 32'd9);
        chk("mp_invalid_ready", 32'(dispatch_ready), 32'd1);

        // Fill all 16 entries from head = tail = 9
        for (int i = 0; i < 16; i++) begin
            disp(exp_tail);
            chk("fill_ready", 32'(dispatch_ready), (i < 15) ? 32'd1 : 32'd0);
        end
        dispatch_valid   = 1'b1;
        dispatch_rob_tag = 4'd9;
        wb0_valid        = 1'b1;
        wb0_tag          = 4'd9;
        tick();
        wb0_valid = 1'b0;
        chk("full_ready", 32'(dispatch_ready), 32'd0);
        chk("full_tail", 32'(rob_tail_tag), 32'd9);
        chk("full_retire", 32'(commit_retire), 32'd0);
        tick();
        chk("full_commit_retire", 32'(commit_retire), 32'd1);
        chk("full_commit_tag", 32'(commit_tag), 32'd9);
        chk("full_ready_again", 32'(dispatch_ready), 32'd1);
        chk("full_17th_dropped", 32'(rob_tail_tag), 32'd9);
        idle_inputs();
        tick();
        cq.delete();
        for (int i = 0; i < 15; i++) begin
            wb0_valid = 1'b1;
            wb0_tag   = 4'(10 + i);
            tick();
        end
        wb0_valid = 1'b0;
        repeat (3) tick();
        eq.delete();
        for (int i = 0; i < 15; i++) eq.push_back(4'(10 + i));
        chk_queue("drain");

        // Advance head and tail to 14
        for (int i = 0; i < 5; i++) disp(exp_tail);
        for (int i = 0; i < 5; i++) begin
            wb0_valid = 1'b1;
            wb0_tag   = 4'(9 + i);
            tick();
        end
        wb0_valid = 1'b0;
        repeat (3) tick();

        // Wrap-around 14,15,0,1
        cq.delete();
        for (int i = 0; i < 4; i++) disp(exp_tail);
        chk("wrap_tail", 32'(rob_tail_tag), 32'd2);
        wb0_valid = 1'b1; wb0_tag = 4'd14; wb1_valid = 1'b1; wb1_tag = 4'd15;
        tick();
        wb0_tag = 4'd0; wb1_tag = 4'd1;
        tick();
        idle_inputs();
        repeat (4) tick();
        eq = '{4'd14, 4'd15, 4'd0, 4'd1};
        chk_queue("wrap_commits");

        // Tag mismatch is sticky until reset; reset discards a done entry
        chk("tag_error_clear", 32'(tag_error), 32'd0);
        dispatch_valid     = 1'b1;
        dispatch_rob_tag   = 4'd7;
        dispatch_reg_write = 1'b1;
        tick();
        dispatch_valid = 1'b0;
        chk("tag_error_set", 32'(tag_error), 32'd1);
        chk("tag_error_tail", 32'(rob_tail_tag), 32'd3);
        wb0_valid = 1'b1;
        wb0_tag   = 4'd2;
        tick();
        wb0_valid = 1'b0;
        chk("tag_error_sticky", 32'(tag_error), 32'd1);
        reset = 1'b0;
        tick();
        chk("midrst_retire", 32'(commit_retire), 32'd0);
        chk("midrst_tag_error", 32'(tag_error), 32'd0);
        chk("midrst_tail", 32'(rob_tail_tag), 32'd0);
        chk("midrst_ready", 32'(dispatch_ready), 32'd0);
        tick();
        reset = 1'b1;
        cq.delete();
        repeat (3) tick();
        eq.delete();
        chk_queue("midrst_commits");
        chk("midrst_ready_after", 32'(dispatch_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
